uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver that turns a serial `rx` line into an AXI-stream of words. Compared to the basic receiver it adds configurable word width and stop-bit count, an input synchroniser, start-bit glitch rejection, stop-bit (framing) checking with break handling, optional parity checking, and an output FIFO that absorbs back-pressure. It sits between the pad-level `rx` input and any AXI-stream consumer in the design.

## Interface
- `cycles_per_bit`, 434, clock cycles per serial bit; must be ≥ 4.
- `data_width`, 8, data bits per frame, 5..9, sent LSB first.
- `stop_bits`, 1, stop bits checked per frame, 1 or 2.
- `parity_odd`, 0, 0 = even parity, 1 = odd parity; used only with `UART_RX_PARITY_EN`.
- `fifo_depth`, 4, output FIFO depth in words; a power of two, ≥ 2.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `tready`  in  1  AXI-stream ready from the consumer.
- `tvalid`  out  1  AXI-stream valid; FIFO is not empty.
- `tdata`  out  `data_width`  AXI-stream data; the FIFO head word.
- `overflow`  out  1  one-cycle pulse: a good word was dropped because the FIFO was full.
- `frame_error`  out  1  one-cycle pulse: a stop bit was sampled low.
- `parity_error`  out  1  one-cycle pulse: parity mismatch. Tied to 0 without `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`). Both flops reset to 1. All decisions below use `rx_s`.
- `cycles` counter: width is `$clog2(cycles_per_bit)`. `index` counter: width is `$clog2(data_width)`. The shift register holds `data_width` bits and fills LSB-first: new bit enters at the MSB and the register shifts right.
- State machine states: `IDLE`, `DATA`, `PARITY`, `STOP`, `BREAK`.
  - `IDLE`: while `rx_s` is 0, count up. Any 1 clears the count (glitch rejection). When the count reaches `cycles_per_bit/2-1` → `DATA`, with `cycles`=0 and `index`=0.
  - `DATA`: sample when `cycles`=`cycles_per_bit-1`. After bit `data_width-1`:
    - go to `PARITY` if parity is enabled;
    - otherwise go to `STOP`.
  - `PARITY`: sample one bit, then → `STOP`. The error condition is XOR(data, parity bit) ≠ `parity_odd`.
  - `STOP`: sample `stop_bits` bits, one per `cycles_per_bit`.
    - A low stop bit raises `frame_error` and moves to `BREAK` immediately; any remaining stop bits are not sampled.
    - After the last good stop bit the frame is resolved, then → `IDLE`.
  - `BREAK`: wait until `rx_s`=1, then → `IDLE`. A held-low line therefore gives exactly one `frame_error`.
- Frame resolution, in priority order:
  - framing error: word discarded, `frame_error` pulses;
  - parity error: word discarded, `parity_error` pulses;
  - FIFO full with no pop in the same cycle: word discarded, `overflow` pulses;
  - otherwise: word pushed into the FIFO.
- FIFO behaviour:
  - Pop happens when `tvalid && tready`.
  - A push and a pop in the same cycle are both accepted, including when the FIFO is full. No overflow is flagged in that case.
  - Read and write pointers wrap modulo `fifo_depth`. An occupancy counter has width `$clog2(fifo_depth)+1`.
- `tdata` is undefined while `tvalid`=0.
- Reset in mid-frame:
  - state → `IDLE`, counters → 0, FIFO emptied;
  - all outputs → 0 (`tvalid`, `overflow`, `frame_error`, `parity_error`);
  - the partially received frame is lost.

## Timing
- Sampling point: centre of each bit, counted from the synchronised falling edge. Sampling jitter is ±1 clk.
- Push happens on the cycle of the last stop-bit sample. `tvalid` rises on the next cycle, so latency from the last stop-bit sample to `tvalid` is 1 cycle. The error and overflow pulses also appear in that cycle.
- Total latency from the line edge to `tvalid` is 2 cycles (synchroniser) plus 1 cycle.
- `tvalid` and `tdata` stay stable until the handshake completes. Once valid, they do not depend combinationally on `tready`.
- A new start bit is accepted on the first `IDLE` cycle after the stop bit. Back-to-back frames with no idle gap are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the `PARITY` state exists;
  - the frame is start, data, parity, stop;
  - `parity_error` is active.
- `UART_RX_PARITY_EN` undefined:
  - the `PARITY` state and parity logic are not compiled;
  - the frame is start, data, stop;
  - `parity_error` is constant 0;
  - `parity_odd` is ignored.

## Test plan
All scenarios use `cycles_per_bit`=16 and `data_width`=8 unless noted.
- Send 0x55, then 0xA3 back-to-back with `tready`=1 → two beats, `tdata` 0x55 then 0xA3. No error pulses.
- `tready`=0; send 5 words with `fifo_depth`=4 → 4 words held, `overflow` pulses once on the 5th. Then `tready`=1 → 0x01..0x04 drained in order.
- Stop bit forced low on 0x3C, then `rx` held low for 100 bit times → exactly one `frame_error`, no beat. The next good frame 0x7E is received.
- 4-cycle low glitch on an idle line → no state change, no output.
- With `UART_RX_PARITY_EN` and `parity_odd`=0: send 0x07 with parity bit 1 → accepted. Send 0x07 with parity bit 0 → `parity_error` pulse, no beat.
- Assert `rst` for 1 cycle mid-way through the data bits, with 2 words in the FIFO → `tvalid`=0 next cycle, FIFO empty. A following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with an AXI-stream output FIFO.
//
// Receives start / data (LSB first) / [parity] / stop frames on an asynchronous
// rx line, checks the stop bit(s) and optional parity, and pushes good words into
// a small FIFO that drives an AXI-stream master port.
//
// Optional feature macro: UART_RX_PARITY_EN. When defined, a parity bit follows
// the data bits and parity_error is live. When undefined, the parity state and
// logic are not built and parity_error is constant 0.
//
// Parameters:
//   cycles_per_bit  clock cycles per serial bit (>= 4)
//   data_width      data bits per frame (5..9)
//   stop_bits       stop bits checked per frame (1 or 2)
//   parity_odd      0 = even parity, 1 = odd parity (parity builds only)
//   fifo_depth      output FIFO depth in words (power of two, >= 2)
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   tready        AXI-stream ready from the consumer
//   tvalid        AXI-stream valid (FIFO not empty)
//   tdata         AXI-stream data (FIFO head word)
//   overflow      1-cycle pulse: good word dropped because the FIFO was full
//   frame_error   1-cycle pulse: a stop bit was sampled low
//   parity_error  1-cycle pulse: parity mismatch (0 without parity)

module uart_rx_fifo #(
  parameter int unsigned cycles_per_bit = 434,
  parameter int unsigned data_width     = 8,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned parity_odd     = 0,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  tready,
  output logic                  tvalid,
  output logic [data_width-1:0] tdata,
  output logic                  overflow,
  output logic                  frame_error,
  output logic                  parity_error
);

  localparam int unsigned CycW = $clog2(cycles_per_bit);
  localparam int unsigned IdxW = $clog2(data_width);
  localparam int unsigned PtrW = $clog2(fifo_depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CycW-1:0] LastCycle = CycW'(cycles_per_bit - 1);
  localparam logic [CycW-1:0] HalfCycle = CycW'(cycles_per_bit / 2 - 1);
  localparam logic [IdxW-1:0] LastIndex = IdxW'(data_width - 1);
  localparam logic            LastStop  = (stop_bits == 2);
  localparam logic [CntW-1:0] FullCount = CntW'(fifo_depth);
  localparam logic            ParityOdd = (parity_odd != 0);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StStop,
    StBreak
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser (resets to the idle line level)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM and datapath
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CycW-1:0]       cycles_q, cycles_d;
  logic [IdxW-1:0]       index_q, index_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  bit_done;
  logic                  frame_ok;       // last stop bit sampled high
  logic                  frame_err_set;  // a stop bit sampled low
  logic                  parity_bad;

  assign bit_done = (cycles_q == LastCycle);

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q, parity_bit_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q && cycles_q == HalfCycle) state_d = StData;
      end
      StData: begin
        if (bit_done && index_q == LastIndex) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_done) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_done) begin
          if (!rx_s_q) begin
            state_d = StBreak;
          end else if (stop_cnt_q == LastStop) begin
            state_d = StIdle;
          end
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath / event outputs of the FSM
  always_comb begin
    cycles_d      = cycles_q;
    index_d       = index_q;
    shift_d       = shift_q;
    stop_cnt_d    = stop_cnt_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d  = parity_bit_q;
`endif
    frame_ok      = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Any high sample restarts the start-bit qualification (glitch filter).
        if (rx_s_q) begin
          cycles_d = '0;
        end else if (cycles_q == HalfCycle) begin
          cycles_d   = '0;
          index_d    = '0;
          stop_cnt_d = 1'b0;
        end else begin
          cycles_d = cycles_q + CycW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          cycles_d = '0;
          shift_d  = {rx_s_q, shift_q[data_width-1:1]};
          index_d  = index_q + IdxW'(1);
        end else begin
          cycles_d = cycles_q + CycW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          cycles_d     = '0;
          parity_bit_d = rx_s_q;
        end else begin
          cycles_d = cycles_q + CycW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          cycles_d = '0;
          if (!rx_s_q) begin
            frame_err_set = 1'b1;
          end else if (stop_cnt_q == LastStop) begin
            frame_ok = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          cycles_d = cycles_q + CycW'(1);
        end
      end
      StBreak: begin
        cycles_d = '0;
      end
      default: begin
        cycles_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q   <= '0;
      index_q    <= '0;
      shift_q    <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      cycles_q   <= cycles_d;
      index_q    <= index_d;
      shift_q    <= shift_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit_q <= 1'b0;
    end else begin
      parity_bit_q <= parity_bit_d;
    end
  end

  assign parity_bad = frame_ok && ((^shift_q ^ parity_bit_q) != ParityOdd);
`else
  // parity_odd has no effect in this build.
  assign parity_bad = 1'b0 & ParityOdd;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [data_width-1:0] mem_q [fifo_depth];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full;
  logic                  push_req, push, pop;
  logic                  overflow_set;

  assign full         = (count_q == FullCount);
  assign pop          = tvalid && tready;
  assign push_req     = frame_ok && !parity_bad;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push         = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= shift_q;
  end

  assign tvalid = (count_q != '0);
  assign tdata  = mem_q[rptr_q];

  // ---------------------------------------------------------------------------
  // Status pulses, registered so they line up with the tvalid rise
  // ---------------------------------------------------------------------------
  logic overflow_q, frame_error_q, parity_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      overflow_q     <= overflow_set;
      frame_error_q  <= frame_err_set;
      parity_error_q <= parity_bad;
    end
  end

  assign overflow     = overflow_q;
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: a vector table of single frames plus
// hand-written sequences for back-to-back, overflow, break, glitch, reset and
// (with UART_RX_PARITY_EN) parity cases.

module tb_uart_rx_fifo;

  localparam int   CPB          = 16;
  localparam int   DW           = 8;
  localparam int   FD           = 4;
  localparam logic PAR_ODD_BIT  = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          tready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          overflow;
  logic          frame_error;
  logic          parity_error;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .cycles_per_bit(CPB),
    .data_width    (DW),
    .stop_bits     (1),
    .parity_odd    (0),
    .fifo_depth    (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .tready      (tready),
    .tvalid      (tvalid),
    .tdata       (tdata),
    .overflow    (overflow),
    .frame_error (frame_error),
    .parity_error(parity_error)
  );

  int checks = 0;
  int passes = 0;

  // Monitor: collects accepted beats and counts status pulses.
  logic [DW-1:0] beats[$];
  int fe_cnt;
  int ov_cnt;
  int pe_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) beats.push_back(tdata);
      if (frame_error)  fe_cnt++;
      if (overflow)     ov_cnt++;
      if (parity_error) pe_cnt++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    pe_cnt = 0;
  endtask

  function automatic int beat_at(input int i);
    if (beats.size() > i) return int'(beats[i]);
    return -1;
  endfunction

  // All driving happens 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_level);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PAR_ODD_BIT);
`endif
    drive_bit(stop_level);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(~((^d) ^ PAR_ODD_BIT));
    drive_bit(1'b1);
  endtask
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_level;
    int         exp_beats;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 8'h55, stop_level: 1'b1, exp_beats: 1, exp_fe: 0};
    vecs[1] = '{data: 8'hA3, stop_level: 1'b1, exp_beats: 1, exp_fe: 0};
    vecs[2] = '{data: 8'h00, stop_level: 1'b1, exp_beats: 1, exp_fe: 0};
    vecs[3] = '{data: 8'hFF, stop_level: 1'b1, exp_beats: 1, exp_fe: 0};
    vecs[4] = '{data: 8'h3C, stop_level: 1'b0, exp_beats: 0, exp_fe: 1};
    vecs[5] = '{data: 8'h81, stop_level: 1'b1, exp_beats: 1, exp_fe: 0};

    rst    = 1'b1;
    rx     = 1'b1;
    tready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", int'(tvalid), 0);
    check("reset_frame_error", int'(frame_error), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_parity_error", int'(parity_error), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single-frame vector table
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop_level);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check($sformatf("vec%0d_beats", v), beats.size(), vecs[v].exp_beats);
      check($sformatf("vec%0d_frame_error", v), fe_cnt, vecs[v].exp_fe);
      check($sformatf("vec%0d_other_pulses", v), ov_cnt + pe_cnt, 0);
      if (vecs[v].exp_beats != 0) begin
        check($sformatf("vec%0d_data", v), beat_at(0), int'(vecs[v].data));
      end
    end

    // Back-to-back frames, no idle gap
    clear_mon();
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("b2b_beats", beats.size(), 2);
    check("b2b_first", beat_at(0), 8'h55);
    check("b2b_second", beat_at(1), 8'hA3);
    check("b2b_errors", fe_cnt + ov_cnt + pe_cnt, 0);

    // Back-pressure: fifth word overflows, first four drain in order
    clear_mon();
    tready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    drive_bit(1'b1);
    check("ovf_pulses", ov_cnt, 1);
    check("ovf_no_beats", beats.size(), 0);
    check("ovf_tvalid_held", int'(tvalid), 1);
    check("ovf_head", int'(tdata), 8'h01);
    tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_beats", beats.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), beat_at(k), k + 1);
    check("drain_empty", int'(tvalid), 0);

    // Framing error followed by a long break
    clear_mon();
    send_frame(8'h3C, 1'b0);
    repeat (100) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("break_frame_error", fe_cnt, 1);
    check("break_no_beat", beats.size(), 0);
    clear_mon();
    send_frame(8'h7E, 1'b1);
    drive_bit(1'b1);
    check("after_break_beats", beats.size(), 1);
    check("after_break_data", beat_at(0), 8'h7E);

    // Short low glitches are rejected (each alone is below half a bit)
    clear_mon();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    repeat (3) drive_bit(1'b1);
    check("glitch_no_beat", beats.size(), 0);
    check("glitch_no_pulse", fe_cnt + ov_cnt + pe_cnt, 0);
    send_frame(8'h96, 1'b1);
    drive_bit(1'b1);
    check("post_glitch_beats", beats.size(), 1);
    check("post_glitch_data", beat_at(0), 8'h96);

    // Reset in mid-frame with two words queued
    clear_mon();
    tready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive_bit(1'b1);
    check("pre_reset_tvalid", int'(tvalid), 1);
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_reset_tvalid", int'(tvalid), 0);
    check("mid_reset_frame_error", int'(frame_error), 0);
    repeat (6) drive_bit(1'b1);
    clear_mon();
    tready = 1'b1;
    send_frame(8'hC3, 1'b1);
    drive_bit(1'b1);
    check("post_reset_beats", beats.size(), 1);
    check("post_reset_data", beat_at(0), 8'hC3);
    check("post_reset_errors", fe_cnt + ov_cnt + pe_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    clear_mon();
    send_frame(8'h07, 1'b1);
    drive_bit(1'b1);
    check("par_good_beats", beats.size(), 1);
    check("par_good_data", beat_at(0), 8'h07);
    check("par_good_pe", pe_cnt, 0);
    clear_mon();
    send_bad_parity(8'h07);
    drive_bit(1'b1);
    check("par_bad_pe", pe_cnt, 1);
    check("par_bad_beats", beats.size(), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
